gap_average_writer: RTL and testbench

//  Global-average-pooling front end for the 16-channel average register bank.

---
 rtl/gap_average_writer_if.sv | 30 +++
 rtl/gap_average_writer.sv | 190 +++++++++++++++++++
 tb/tb_gap_average_writer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/gap_average_writer_if.sv
// Handshake and write-port bundle between the pixel source, the averaging front end and the register bank.
`timescale 1ns/1ps
interface gap_average_writer_if #(
  parameter int DW = 10
);
  logic          start;
  logic          abort;
  logic          valid;
  logic          ready;
  logic [DW-1:0] pix0;
  logic [DW-1:0] pix1;
  logic [DW-1:0] pix2;
  logic          enable_write;
  logic [15:0]   sel_write;
  logic [DW-1:0] data0;
  logic [DW-1:0] data1;
  logic [DW-1:0] data2;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, valid, pix0, pix1, pix2,
    input  ready, enable_write, sel_write, data0, data1, data2, busy, done
  );

  modport slave (
    input  start, abort, valid, pix0, pix1, pix2,
    output ready, enable_write, sel_write, data0, data1, data2, busy, done
  );
endinterface

// File: rtl/gap_average_writer.sv
// Global-average-pooling front end: accumulates NPIX beats for three channels per group
// and writes the rounded averages of all 16 channels into the average bank, one group per strobe.
`timescale 1ns/1ps
module gap_average_writer #(
  parameter int LOG2_NPIX = 4,
  parameter int DW        = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  gap_average_writer_if.slave  bus
);
  localparam int         AW         = DW + LOG2_NPIX;
  localparam int         NPIX       = 2 ** LOG2_NPIX;
  localparam logic [2:0] LAST_GROUP = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_r;
  logic [2:0]             group_r;
  logic [LOG2_NPIX-1:0]   beat_r;
  logic [AW-1:0]          acc0_r, acc1_r, acc2_r;
  logic                   ready_r, busy_r, done_r, enable_write_r;
  logic [15:0]            sel_write_r;
  logic [DW-1:0]          data0_r, data1_r, data2_r;
  logic [AW-1:0]          sum0_s, sum1_s, sum2_s;
  logic                   last_beat_s;

  function automatic logic [15:0] sel_for_group(input logic [2:0] g);
    case (g)
      3'd0:    return 16'h0007;
      3'd1:    return 16'h0038;
      3'd2:    return 16'h01C0;
      3'd3:    return 16'h0E00;
      3'd4:    return 16'h7000;
      3'd5:    return 16'h8000;
      default: return 16'h0000;
    endcase
  endfunction

  // Round half up; the extra bit keeps the bias addition from wrapping.
  function automatic logic [DW-1:0] round_avg(input logic [AW-1:0] acc);
    logic [AW:0] biased;
    biased = {1'b0, acc} + (AW+1)'(NPIX / 2);
    return DW'(biased >> LOG2_NPIX);
  endfunction

  // Running sums including the current beat; channel 15 has no partners, so its slots add zero.
  always_comb begin
    sum0_s = acc0_r + AW'(bus.pix0);
    sum1_s = acc1_r;
    sum2_s = acc2_r;
    if (group_r != LAST_GROUP) begin
      sum1_s = acc1_r + AW'(bus.pix1);
      sum2_s = acc2_r + AW'(bus.pix2);
    end else begin
      sum1_s = acc1_r;
      sum2_s = acc2_r;
    end
  end

  assign last_beat_s = &beat_r;

  // Pass sequencer with registered outputs; write strobe and data are only non-zero in WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      group_r        <= 3'd0;
      beat_r         <= '0;
      acc0_r         <= '0;
      acc1_r         <= '0;
      acc2_r         <= '0;
      ready_r        <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      enable_write_r <= 1'b0;
      sel_write_r    <= 16'h0000;
      data0_r        <= '0;
      data1_r        <= '0;
      data2_r        <= '0;
    end else begin
      enable_write_r <= 1'b0;
      sel_write_r    <= 16'h0000;
      data0_r        <= '0;
      data1_r        <= '0;
      data2_r        <= '0;
      done_r         <= 1'b0;
      case (state_r)
        IDLE: begin
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          if (bus.start) begin
            group_r <= 3'd0;
            beat_r  <= '0;
            acc0_r  <= '0;
            acc1_r  <= '0;
            acc2_r  <= '0;
            ready_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ACCUM;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCUM: begin
          if (bus.abort) begin
            state_r <= IDLE;
            group_r <= 3'd0;
            beat_r  <= '0;
            acc0_r  <= '0;
            acc1_r  <= '0;
            acc2_r  <= '0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
          end else if (bus.valid) begin
            acc0_r <= sum0_s;
            acc1_r <= sum1_s;
            acc2_r <= sum2_s;
            beat_r <= beat_r + 1'b1;
            if (last_beat_s) begin
              state_r        <= WRITE;
              ready_r        <= 1'b0;
              enable_write_r <= 1'b1;
              sel_write_r    <= sel_for_group(group_r);
              data0_r        <= round_avg(sum0_s);
              data1_r        <= round_avg(sum1_s);
              data2_r        <= round_avg(sum2_s);
            end else begin
              state_r <= ACCUM;
            end
          end else begin
            state_r <= ACCUM;
          end
        end
        WRITE: begin
          beat_r <= '0;
          acc0_r <= '0;
          acc1_r <= '0;
          acc2_r <= '0;
          if (bus.abort) begin
            state_r <= IDLE;
            group_r <= 3'd0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
          end else if (group_r != LAST_GROUP) begin
            group_r <= group_r + 3'd1;
            ready_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ACCUM;
          end else begin
            group_r <= 3'd0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
          group_r <= 3'd0;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          group_r <= 3'd0;
          beat_r  <= '0;
          acc0_r  <= '0;
          acc1_r  <= '0;
          acc2_r  <= '0;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready        = ready_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.enable_write = enable_write_r;
  assign bus.sel_write    = sel_write_r;
  assign bus.data0        = data0_r;
  assign bus.data1        = data1_r;
  assign bus.data2        = data2_r;
endmodule

// File: tb/tb_gap_average_writer.sv
// Randomized bench for gap_average_writer: per-group sums are kept in plain integers and averaged
// with integer arithmetic, then compared against each write strobe.
`timescale 1ns/1ps
module tb_gap_average_writer;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  gap_average_writer_if #(.DW(10)) bus ();

  gap_average_writer #(.LOG2_NPIX(4), .DW(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned sel_table [6] = '{32'h0007, 32'h0038, 32'h01C0, 32'h0E00, 32'h7000, 32'h8000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_en"},    32'(bus.enable_write), 32'd0);
    check({tag, "_sel"},   32'(bus.sel_write),    32'd0);
    check({tag, "_data0"}, 32'(bus.data0),        32'd0);
    check({tag, "_done"},  32'(bus.done),         32'd0);
  endtask

  // vmode: 0 steady valid, 1 toggling, 2 random. pmode: 0 all 100, 1 rounding corner,
  // 2 random, 3 group-5 fixed values. abort_grp/reset_grp < 0 disable those events.
  task automatic run_pass(input int vmode, input int pmode, input int abort_grp, input int reset_grp);
    int unsigned s0, s1, s2;
    int beats, cyc;
    logic v;
    logic [9:0] p0, p1, p2;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    for (int g = 0; g < 6; g++) begin
      s0 = 0; s1 = 0; s2 = 0; beats = 0; cyc = 0;
      while (beats < 16) begin
        check("ready_accum", 32'(bus.ready), 32'd1);
        check("no_early_strobe", 32'(bus.enable_write), 32'd0);
        check("sel_idle_zero", 32'(bus.sel_write), 32'd0);
        case (vmode)
          0:       v = 1'b1;
          1:       v = (cyc % 2) == 0;
          default: v = 1'($urandom_range(0, 1));
        endcase
        p0 = 10'($urandom_range(0, 1023));
        p1 = 10'($urandom_range(0, 1023));
        p2 = 10'($urandom_range(0, 1023));
        if (pmode == 0) begin
          p0 = 10'd100; p1 = 10'd100; p2 = 10'd100;
        end else if (pmode == 1 && g == 0) begin
          p0 = (beats == 15) ? 10'd8 : 10'd0;
          p1 = (beats == 15) ? 10'd7 : 10'd0;
          p2 = 10'd1023;
        end else if (pmode == 3 && g == 5) begin
          p0 = 10'd40; p1 = 10'd500; p2 = 10'd500;
        end
        bus.start = ($urandom_range(0, 3) == 0);
        bus.valid = v;
        bus.pix0 = p0; bus.pix1 = p1; bus.pix2 = p2;
        if (v) begin
          beats++;
          s0 += p0;
          if (g < 5) begin
            s1 += p1;
            s2 += p2;
          end
        end
        if (g == abort_grp && v && beats == 7) begin
          bus.abort = 1'b1;
          @(negedge clk);
          bus.abort = 1'b0;
          bus.start = 1'b0;
          check("abort_ready", 32'(bus.ready), 32'd0);
          check("abort_busy", 32'(bus.busy), 32'd0);
          check_quiet_outputs("abort");
          repeat (40) begin
            bus.valid = 1'b1;
            @(negedge clk);
            check("post_abort_no_strobe", 32'(bus.enable_write), 32'd0);
            check("post_abort_no_done", 32'(bus.done), 32'd0);
            check("post_abort_ready", 32'(bus.ready), 32'd0);
          end
          bus.valid = 1'b0;
          return;
        end
        @(negedge clk);
        cyc++;
      end
      bus.valid = 1'b0;
      bus.start = 1'b0;
      check("strobe", 32'(bus.enable_write), 32'd1);
      check("sel", 32'(bus.sel_write), sel_table[g]);
      check("data0", 32'(bus.data0), (s0 + 8) / 16);
      check("data1", 32'(bus.data1), (s1 + 8) / 16);
      check("data2", 32'(bus.data2), (s2 + 8) / 16);
      check("ready_write", 32'(bus.ready), 32'd0);
      check("busy_write", 32'(bus.busy), 32'd1);
      if (g == reset_grp) begin
        rst = 1'b1;
        #1;
        check("rst_write_en", 32'(bus.enable_write), 32'd0);
        check("rst_write_sel", 32'(bus.sel_write), 32'd0);
        check("rst_write_data0", 32'(bus.data0), 32'd0);
        check("rst_write_busy", 32'(bus.busy), 32'd0);
        check("rst_write_ready", 32'(bus.ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("done_pulse", 32'(bus.done), 32'd1);
    check("done_busy", 32'(bus.busy), 32'd0);
    check("done_no_strobe", 32'(bus.enable_write), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("idle_ready", 32'(bus.ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.valid = 1'b0;
    bus.pix0 = '0; bus.pix1 = '0; bus.pix2 = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(bus.ready), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_data12", 32'({bus.data1, bus.data2}), 32'd0);
    check_quiet_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_ready", 32'(bus.ready), 32'd0);

    run_pass(0, 0, -1, -1);
    run_pass(0, 1, -1, -1);
    run_pass(1, 0, -1, -1);
    run_pass(2, 3, -1, -1);
    run_pass(2, 2, 2, -1);
    run_pass(0, 2, -1, -1);
    run_pass(2, 2, -1, 3);
    run_pass(2, 2, -1, -1);
    for (int i = 0; i < 3; i++) run_pass(2, 2, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
